// File: rtl/cell_pixel_streamer_if.sv
// Pixel-source bundle: cell RAM read port plus the valid/ready pixel stream and frame markers.
interface cell_pixel_streamer_if #(
    parameter int AW = 13
);
    logic [AW-1:0] cell_addr;
    logic          cell_rd;
    logic          cell_rdata;
    logic          pixel_tvalid;
    logic          pixel_tready;
    logic [11:0]   pixel_tdata;
    logic          frame_start;
    logic          frame_done;

    modport master (
        output cell_addr, cell_rd, pixel_tvalid, pixel_tdata, frame_start, frame_done,
        input  cell_rdata, pixel_tready
    );

    modport slave (
        input  cell_addr, cell_rd, pixel_tvalid, pixel_tdata, frame_start, frame_done,
        output cell_rdata, pixel_tready
    );
endinterface

// File: rtl/cell_pixel_streamer.sv
// Walks the Conway cell bitmap in raster order, scales each cell to a square pixel block and
// streams one 12-bit colour per valid/ready transfer through a 2-entry skid buffer.
module cell_pixel_streamer #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          CELL_SHIFT  = 3,
    parameter logic [11:0] ALIVE_COLOR = 12'hFFF,
    parameter logic [11:0] DEAD_COLOR  = 12'h000
) (
    input  logic                  clk,
    input  logic                  reset,
    cell_pixel_streamer_if.master bus
);
    localparam int GRID_W = H_ACTIVE >> CELL_SHIFT;
    localparam int GRID_H = V_ACTIVE >> CELL_SHIFT;
    localparam int AW     = $clog2(GRID_W * GRID_H);
    localparam int XW     = $clog2(H_ACTIVE);
    localparam int YW     = $clog2(V_ACTIVE);

    function automatic logic [11:0] cell_color(input logic alive);
        return alive ? ALIVE_COLOR : DEAD_COLOR;
    endfunction

    logic          run_q, run_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d, y_inc;
    logic [AW-1:0] row_base_q, row_base_d;
    logic          rvld_q, rvld_d;
    logic          rsof_q, rsof_d, reof_q, reof_d;
    logic          head_vld_q, head_vld_d;
    logic [11:0]   head_data_q, head_data_d;
    logic          head_sof_q, head_sof_d, head_eof_q, head_eof_d;
    logic          skid_vld_q, skid_vld_d;
    logic [11:0]   skid_data_q, skid_data_d;
    logic          skid_sof_q, skid_sof_d, skid_eof_q, skid_eof_d;
    logic          frame_start_q, frame_start_d;
    logic          frame_done_q, frame_done_d;
    logic          rd, pop, x_last, y_last;
    logic [2:0]    slots_used;
    logic [11:0]   push_data;

    always_comb begin
        run_d        = 1'b1;
        pop          = head_vld_q && bus.pixel_tready;
        // Entries that will still occupy the buffer after this cycle's pop, counting the read
        // whose data returns now; issuing only below 2 keeps the skid buffer from overflowing.
        slots_used   = 3'(head_vld_q) + 3'(skid_vld_q) + 3'(rvld_q) - 3'(pop);
        rd           = run_q && (slots_used < 3'd2);
        x_last       = (x_q == XW'(H_ACTIVE - 1));
        y_last       = (y_q == YW'(V_ACTIVE - 1));
        y_inc        = y_q + 1'b1;
        x_d          = x_q;
        y_d          = y_q;
        row_base_d   = row_base_q;
        rvld_d       = rd;
        rsof_d       = rd && (x_q == '0) && (y_q == '0);
        reof_d       = rd && x_last && y_last;
        if (rd) begin
            if (!x_last) begin
                x_d = x_q + 1'b1;
            end else begin
                x_d = '0;
                if (y_last) begin
                    y_d        = '0;
                    row_base_d = '0;
                end else begin
                    y_d = y_inc;
                    if (y_inc[CELL_SHIFT-1:0] == '0) row_base_d = row_base_q + AW'(GRID_W);
                end
            end
        end

        // Return stage / skid buffer: head drives the output, skid catches a push under stall.
        push_data    = cell_color(bus.cell_rdata);
        head_vld_d   = head_vld_q;
        head_data_d  = head_data_q;
        head_sof_d   = head_sof_q;
        head_eof_d   = head_eof_q;
        skid_vld_d   = skid_vld_q;
        skid_data_d  = skid_data_q;
        skid_sof_d   = skid_sof_q;
        skid_eof_d   = skid_eof_q;
        if (!head_vld_q || pop) begin
            if (skid_vld_q) begin
                head_vld_d  = 1'b1;
                head_data_d = skid_data_q;
                head_sof_d  = skid_sof_q;
                head_eof_d  = skid_eof_q;
                skid_vld_d  = rvld_q;
                skid_data_d = push_data;
                skid_sof_d  = rsof_q;
                skid_eof_d  = reof_q;
            end else begin
                head_vld_d  = rvld_q;
                if (rvld_q) begin
                    head_data_d = push_data;
                    head_sof_d  = rsof_q;
                    head_eof_d  = reof_q;
                end
                skid_vld_d  = 1'b0;
            end
        end else if (rvld_q) begin
            skid_vld_d  = 1'b1;
            skid_data_d = push_data;
            skid_sof_d  = rsof_q;
            skid_eof_d  = reof_q;
        end

        frame_start_d = pop && head_sof_q;
        frame_done_d  = pop && head_eof_q;
    end

    // Fetch / return / output stage boundary (control state)
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q         <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            row_base_q    <= '0;
            rvld_q        <= 1'b0;
            head_vld_q    <= 1'b0;
            head_data_q   <= DEAD_COLOR;
            skid_vld_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            run_q         <= run_d;
            x_q           <= x_d;
            y_q           <= y_d;
            row_base_q    <= row_base_d;
            rvld_q        <= rvld_d;
            head_vld_q    <= head_vld_d;
            head_data_q   <= head_data_d;
            skid_vld_q    <= skid_vld_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Payload and tag registers, qualified by the valid flags above
    always_ff @(posedge clk) begin
        rsof_q      <= rsof_d;
        reof_q      <= reof_d;
        head_sof_q  <= head_sof_d;
        head_eof_q  <= head_eof_d;
        skid_data_q <= skid_data_d;
        skid_sof_q  <= skid_sof_d;
        skid_eof_q  <= skid_eof_d;
    end

    assign bus.cell_rd      = rd;
    assign bus.cell_addr    = row_base_q + AW'(x_q >> CELL_SHIFT);
    assign bus.pixel_tvalid = head_vld_q;
    assign bus.pixel_tdata  = head_data_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.frame_done   = frame_done_q;
endmodule
